// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage core pipeline registers.
// Holds default widths, the decoded control bundle and the ID/EX entry layout.
package pipe_pkg;

  localparam int XLEN_DEF    = 64;
  localparam int REG_AW_DEF  = 5;
  localparam int FUNCT_W_DEF = 4;
  localparam int ALUOP_W_DEF = 2;

  // Bit order matches the id_ctrl/ex_ctrl ports: {MemtoReg,RegWrite,Branch,MemRead,MemWrite,ALUSrc}
  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic branch;
    logic memread;
    logic memwrite;
    logic alusrc;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Entry layout at default widths; parametrised users build the same shape locally
  typedef struct packed {
    logic [XLEN_DEF-1:0]    pc;
    logic [XLEN_DEF-1:0]    rd1;
    logic [XLEN_DEF-1:0]    rd2;
    logic [XLEN_DEF-1:0]    imm;
    logic [REG_AW_DEF-1:0]  rs1;
    logic [REG_AW_DEF-1:0]  rs2;
    logic [REG_AW_DEF-1:0]  rd;
    logic [FUNCT_W_DEF-1:0] funct;
    ctrl_t                  ctrl;
    logic [ALUOP_W_DEF-1:0] aluop;
  } idex_entry_t;

  function automatic logic is_load(input ctrl_t c);
    return c.memread;
  endfunction

endpackage

// File: rtl/idex_hazard_det.sv
// Combinational load-use hazard comparator.
// Flags when the instruction heading into EX is a load whose destination
// is a source of the instruction currently in decode. x0 is never a hazard.
module idex_hazard_det #(
  parameter int REG_AW = 5
) (
  input  logic              m_valid,
  input  logic              m_memread,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              hazard
);

  // Pure compare against the registered EX entry and the decode source fields
  always_comb begin
    hazard = m_valid && m_memread && (m_rd != '0) && id_valid &&
             ((m_rd == id_rs1) || (m_rd == id_rs2));
  end

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Main entry M drives ex_* directly; skid entry S absorbs the one instruction
// accepted in the cycle EX stalls, so id_ready depends only on registered state
// plus the decode source registers (through the load-use check).
// Branch flush kills both entries and zeroes the M control fields.
// Optional build macro IDEX_STATS_EN adds stat_bubbles / stat_flushes counters.
module idex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int FUNCT_W = FUNCT_W_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rd1,
  input  logic [XLEN-1:0]    id_rd2,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [FUNCT_W-1:0] id_funct,
  input  logic [5:0]         id_ctrl,
  input  logic [ALUOP_W-1:0] id_aluop,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rd1,
  output logic [XLEN-1:0]    ex_rd2,
  output logic [XLEN-1:0]    ex_imm,
  output logic [REG_AW-1:0]  ex_rs1,
  output logic [REG_AW-1:0]  ex_rs2,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [FUNCT_W-1:0] ex_funct,
  output logic [5:0]         ex_ctrl,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               load_use_stall
`ifdef IDEX_STATS_EN
  ,
  output logic [31:0]        stat_bubbles,
  output logic [31:0]        stat_flushes
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    imm;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic [REG_AW-1:0]  rd;
    logic [FUNCT_W-1:0] funct;
    ctrl_t              ctrl;
    logic [ALUOP_W-1:0] aluop;
  } entry_t;

  entry_t m_q, m_d, s_q, s_d, id_entry;
  logic   vm_q, vm_d, vs_q, vs_d;
  logic   id_xfer, ex_consume;

  idex_hazard_det #(.REG_AW(REG_AW)) u_hazard (
    .m_valid   (vm_q),
    .m_memread (is_load(m_q.ctrl)),
    .m_rd      (m_q.rd),
    .id_valid  (id_valid),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .hazard    (load_use_stall)
  );

  // Bundle decode fields and derive the two handshakes
  always_comb begin
    id_entry.pc    = id_pc;
    id_entry.rd1   = id_rd1;
    id_entry.rd2   = id_rd2;
    id_entry.imm   = id_imm;
    id_entry.rs1   = id_rs1;
    id_entry.rs2   = id_rs2;
    id_entry.rd    = id_rd;
    id_entry.funct = id_funct;
    id_entry.ctrl  = ctrl_t'(id_ctrl);
    id_entry.aluop = id_aluop;
    id_ready       = !vs_q && !load_use_stall;
    id_xfer        = id_valid && id_ready;
    ex_consume     = vm_q && ex_ready;
  end

  // Next-state for M/S: flush beats consume, consume beats plain accept
  always_comb begin
    m_d  = m_q;
    s_d  = s_q;
    vm_d = vm_q;
    vs_d = vs_q;
    if (flush) begin
      vm_d       = 1'b0;
      vs_d       = 1'b0;
      m_d.ctrl   = CTRL_NOP;
      m_d.aluop  = '0;
    end else if (ex_consume) begin
      if (vs_q) begin
        m_d  = s_q;
        vs_d = 1'b0;
      end else if (id_xfer) begin
        m_d  = id_entry;
        vm_d = 1'b1;
      end else begin
        vm_d = 1'b0;
      end
    end else if (id_xfer) begin
      if (!vm_q) begin
        m_d  = id_entry;
        vm_d = 1'b1;
      end else begin
        s_d  = id_entry;
        vs_d = 1'b1;
      end
    end
  end

  // Entry storage; reset clears both entries so nothing survives a mid-stall reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q  <= '0;
      s_q  <= '0;
      vm_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      m_q  <= m_d;
      s_q  <= s_d;
      vm_q <= vm_d;
      vs_q <= vs_d;
    end
  end

  // M drives the EX stage directly
  always_comb begin
    ex_valid = vm_q;
    ex_pc    = m_q.pc;
    ex_rd1   = m_q.rd1;
    ex_rd2   = m_q.rd2;
    ex_imm   = m_q.imm;
    ex_rs1   = m_q.rs1;
    ex_rs2   = m_q.rs2;
    ex_rd    = m_q.rd;
    ex_funct = m_q.funct;
    ex_ctrl  = m_q.ctrl;
    ex_aluop = m_q.aluop;
  end

`ifdef IDEX_STATS_EN
  logic [31:0] stat_bubbles_q, stat_bubbles_d;
  logic [31:0] stat_flushes_q, stat_flushes_d;

  // Saturating event counters for stall cycles and flushes that killed something
  always_comb begin
    stat_bubbles_d = stat_bubbles_q;
    stat_flushes_d = stat_flushes_q;
    if (load_use_stall && (stat_bubbles_q != '1))
      stat_bubbles_d = stat_bubbles_q + 32'd1;
    if (flush && (vm_q || vs_q) && (stat_flushes_q != '1))
      stat_flushes_d = stat_flushes_q + 32'd1;
  end

  // Counter storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_bubbles_q <= '0;
      stat_flushes_q <= '0;
    end else begin
      stat_bubbles_q <= stat_bubbles_d;
      stat_flushes_q <= stat_flushes_d;
    end
  end

  assign stat_bubbles = stat_bubbles_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule
